// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the multi-cycle CPU.
//
// Single-cycle operations (add, sub, logic, shifts, compares, unknown opcodes,
// and divu by zero) register their result one cycle after start. Unsigned
// multiply (shift-add) and unsigned divide (restoring) iterate one bit per
// cycle for WIDTH cycles and return a double-width result.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   start      operation request, sampled only while busy=0
//   opcode     operation select (4 bits)
//   rega       operand A; shift amount (low SHW bits) for shifts
//   regb       operand B; value shifted for shifts
//   result     low result / quotient
//   result_hi  product high half / remainder; 0 for single-cycle ops
//   zero       1 iff result==0 (registered with result)
//   busy       multiply/divide iteration in progress
//   done       one-cycle pulse when result/result_hi/zero/div_zero update
//   div_zero   set together with done when divu had regb==0
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Combinational result of every operation that completes in one cycle,
  // returned as {hi, lo}. divu by zero is folded in here because it never
  // iterates.
  function automatic logic [2*WIDTH-1:0] single_op(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        lo;
    logic [WIDTH-1:0]        hi;
    sa = $signed(a);
    sb = $signed(b);
    sh = a[SHW-1:0];
    lo = '0;
    hi = '0;
    case (op)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_SLL:  lo = b << sh;
      OP_OR:   lo = a | b;
      OP_AND:  lo = a & b;
      OP_SLTU: lo = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  lo = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_XOR:  lo = a ^ b;
      OP_SRL:  lo = b >> sh;
      OP_SRA:  lo = $unsigned(sb >>> sh);
      OP_DIVU: begin
        lo = '1;
        hi = a;
      end
      default: begin
        lo = '0;
        hi = '0;
      end
    endcase
    return {hi, lo};
  endfunction

  logic [0:0]       state;
  logic [SHW-1:0]   cnt_p0;
  logic             is_div_p0;
  // opnd_p0: multiplicand or divisor. acc_hi_p0/acc_lo_p0: running partial
  // product (multiplier shifts out of acc_lo) or remainder/quotient (dividend
  // shifts out of acc_lo while quotient bits shift in).
  logic [WIDTH-1:0] opnd_p0;
  logic [WIDTH-1:0] acc_hi_p0;
  logic [WIDTH-1:0] acc_lo_p0;

  logic [2*WIDTH-1:0] single_res;
  logic               multi_start;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_hi_nxt;
  logic [WIDTH-1:0]   acc_lo_nxt;
  logic               last_iter;

  always_comb begin
    single_res  = single_op(opcode, rega, regb);
    multi_start = (opcode == OP_MULTU) || ((opcode == OP_DIVU) && (regb != '0));
    last_iter   = (cnt_p0 == SHW'(WIDTH - 1));

    mul_sum = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, opnd_p0} : '0);

    // The partial remainder is always below the divisor, so when the shifted
    // value is >= divisor the true difference fits in WIDTH bits.
    div_sh   = {acc_hi_p0, acc_lo_p0[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_p0});
    div_diff = div_sh[WIDTH-1:0] - opnd_p0;

    if (is_div_p0) begin
      acc_hi_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
      acc_lo_nxt = {acc_lo_p0[WIDTH-2:0], div_ge};
    end else begin
      acc_hi_nxt = mul_sum[WIDTH:1];
      acc_lo_nxt = {mul_sum[0], acc_lo_p0[WIDTH-1:1]};
    end
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt_p0    <= '0;
      is_div_p0 <= 1'b0;
      opnd_p0   <= '0;
      acc_hi_p0 <= '0;
      acc_lo_p0 <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // ---- accept stage: single-cycle ops finish here ----
        IDLE: begin
          if (start) begin
            if (multi_start) begin
              is_div_p0 <= (opcode == OP_DIVU);
              opnd_p0   <= (opcode == OP_DIVU) ? regb : rega;
              acc_lo_p0 <= (opcode == OP_DIVU) ? rega : regb;
              acc_hi_p0 <= '0;
              cnt_p0    <= '0;
              state     <= RUN;
            end else begin
              result    <= single_res[WIDTH-1:0];
              result_hi <= single_res[2*WIDTH-1:WIDTH];
              zero      <= (single_res[WIDTH-1:0] == '0);
              div_zero  <= (opcode == OP_DIVU);
              done      <= 1'b1;
            end
          end
        end
        // ---- iteration stage: one multiplier/quotient bit per cycle ----
        RUN: begin
          acc_hi_p0 <= acc_hi_nxt;
          acc_lo_p0 <= acc_lo_nxt;
          cnt_p0    <= cnt_p0 + 1'b1;
          if (last_iter) begin
            result    <= acc_lo_nxt;
            result_hi <= acc_hi_nxt;
            zero      <= (acc_lo_nxt == '0);
            div_zero  <= 1'b0;
            done      <= 1'b1;
            cnt_p0    <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): the stimulus process pushes the
// hand-computed response of each accepted operation; a monitor on the falling
// edge pops and compares whenever done is high, including the cycle of done.
module tb_alu_seq;
  localparam int WIDTH = 32;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] rega;
  logic [WIDTH-1:0] regb;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_zero;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .rega(rega), .regb(regb), .result(result), .result_hi(result_hi),
    .zero(zero), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             dz;
    int               cyc;
    string            name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 result=0x%0h, expected no done (cyc=%0d)", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, ".result"},    64'(result),    64'(e.lo));
        check({e.name, ".result_hi"}, 64'(result_hi), 64'(e.hi));
        check({e.name, ".zero"},      64'(zero),      64'(e.z));
        check({e.name, ".div_zero"},  64'(div_zero),  64'(e.dz));
        check({e.name, ".done_cycle"}, 64'(cyc),      64'(e.cyc));
      end
    end
  end

  // Drive one start for one cycle, registering the expected response.
  // extra = 0 for single-cycle ops, WIDTH for multiply/divide.
  task automatic send(input string nm, input logic [3:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                      input logic dz, input int extra);
    exp_t e;
    e.lo   = lo;
    e.hi   = hi;
    e.z    = (lo == '0);
    e.dz   = dz;
    e.cyc  = cyc + 1 + extra;
    e.name = nm;
    q.push_back(e);
    opcode = op;
    rega   = a;
    regb   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".result"},    64'(result),    64'h0);
    check({nm, ".result_hi"}, 64'(result_hi), 64'h0);
    check({nm, ".zero"},      64'(zero),      64'h1);
    check({nm, ".busy"},      64'(busy),      64'h0);
    check({nm, ".done"},      64'(done),      64'h0);
    check({nm, ".div_zero"},  64'(div_zero),  64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    opcode = '0;
    rega   = '0;
    regb   = '0;
    #3;
    check_reset_outputs("reset_init");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Consecutive single-cycle ops, one start per cycle.
    send("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,          32'h0, 1'b0, 0);
    send("sub",      OP_SUB,  32'd5,         32'd7,          32'hFFFF_FFFE,  32'h0, 1'b0, 0);
    send("slt",      OP_SLT,  32'h8000_0000, 32'h1,          32'h1,          32'h0, 1'b0, 0);
    send("sltu",     OP_SLTU, 32'h8000_0000, 32'h1,          32'h0,          32'h0, 1'b0, 0);
    send("sra",      OP_SRA,  32'd4,         32'h8000_0000,  32'hF800_0000,  32'h0, 1'b0, 0);
    send("srl",      OP_SRL,  32'd8,         32'h8000_0000,  32'h0080_0000,  32'h0, 1'b0, 0);
    send("and",      OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0,  32'h0F00_0F00,  32'h0, 1'b0, 0);
    send("undef_op", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0,          32'h0, 1'b0, 0);
    send("sll",      OP_SLL,  32'h21,        32'h1,          32'h2,          32'h0, 1'b0, 0);

    // multu back-to-back after sll; hammer start with junk while busy.
    send("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, WIDTH);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      opcode = OP_ADD;
      rega   = $urandom;
      regb   = $urandom;
      start  = 1'b1;
      n++;
      if (n == 10) begin
        check("multu_hold.result",    64'(result),    64'h2);
        check("multu_hold.result_hi", 64'(result_hi), 64'h0);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("multu.busy_cycles", 64'(n), 64'(WIDTH));

    // Issued in the done cycle of multu: must be accepted with no gap.
    send("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, WIDTH);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      rega = $urandom;
      regb = $urandom;
      n++;
      @(posedge clk);
      #1;
    end
    check("divu.busy_cycles", 64'(n), 64'(WIDTH));

    send("divu_zero", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, 0);
    check("divu_zero.busy", 64'(busy), 64'h0);

    // Abort a divide partway through with an asynchronous reset.
    opcode = OP_DIVU;
    rega   = 32'd1000;
    regb   = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(busy), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_midrun");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    send("add_after_reset", OP_ADD, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 0);

    repeat (WIDTH + 4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU: the successor to the single-cycle datapath ALU for the multi-cycle CPU. Single-cycle ops (add, sub, logic, shifts, compares) return a registered result one cycle after `start`. Unsigned multiply and divide run iteratively over WIDTH cycles and return a double-width result. The control FSM drives operands with a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand/result width; ≥ 4, power of two
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only when busy=0
- opcode  in  4  operation select
- rega  in  WIDTH  operand A; shift amount for shifts
- regb  in  WIDTH  operand B; value shifted for shifts
- result  out  WIDTH  low result / quotient
- result_hi  out  WIDTH  product high half / remainder; 0 for single-cycle ops
- zero  out  1  registered, 1 iff result==0
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: result valid
- div_zero  out  1  set with done when divu had regb==0; otherwise 0

## Operation
- Opcodes: 0000 add; 0001 sub; 0010 sll (regb << rega[SHW-1:0]); 0011 or; 0100 and; 0101 sltu; 0110 slt (two's complement); 0111 xor; 1000 srl; 1001 sra; 1010 multu; 1011 divu; others → result=0, result_hi=0, done pulses.
- Add/sub wrap modulo 2^WIDTH; no overflow flag. slt/sltu return 1 or 0 in bit 0.
- Shift amount uses only rega[SHW-1:0]; upper bits ignored.
- multu: {result_hi,result} = rega*regb, unsigned, shift-add, one multiplier bit per cycle.
- divu: result = rega/regb, result_hi = rega%regb, unsigned, restoring, one quotient bit per cycle.
- divu with regb==0: no iteration; result = all ones, result_hi = rega, div_zero=1; completes as a single-cycle op.
- Operands are latched on the accepting edge; input changes after that do not affect the operation in flight.
- FSM states:
  - IDLE: start with a single-cycle op → register result, pulse done, stay IDLE. start with multu/divu (divisor ≠ 0) → latch operands, counter=0 → RUN.
  - RUN: one iteration per cycle; counter increments. After iteration WIDTH-1 → write result/result_hi, pulse done → IDLE.
- result, result_hi, zero, div_zero hold their values until the next done.
- start while busy=1 is ignored; no queueing.

## Timing
- Reset values: result=0, result_hi=0, zero=1, busy=0, done=0, div_zero=0; FSM=IDLE; counter=0.
- Single-cycle op accepted at edge E: done=1 and result valid in cycle E+1 (latency 1). busy stays 0.
- Multi-cycle op accepted at edge E0: busy=1 after E0; iterations at edges E1..EWIDTH. After EWIDTH: busy=0, done=1, outputs valid. Latency = WIDTH cycles.
- Back-to-back: start may be asserted in the same cycle done=1 (busy=0); it is accepted at the next edge with no dead cycle.
- reset asserted mid-RUN: immediate abort, all outputs return to reset values, no done pulse. After deassert, the next start is accepted normally.
- done is never high for two consecutive cycles for a single multi-cycle op. Consecutive single-cycle starts give consecutive done pulses.

## Test plan
- Reset: assert reset asynchronously mid-cycle → all outputs at reset values immediately, zero=1.
- Single-cycle ops, WIDTH=32, one start per cycle:
  - add 0xFFFFFFFF+1 → 0, zero=1
  - sub 5-7 → 0xFFFFFFFE
  - slt 0x80000000,1 → 1
  - sltu same operands → 0
  - sra rega=4, regb=0x80000000 → 0xF8000000
  - sll rega=0x21, regb=1 → 2 (shift by 1)
  - done pulses each cycle.
- multu 0xFFFFFFFF×0xFFFFFFFF → result_hi=0xFFFFFFFE, result=0x00000001; busy high exactly 32 cycles, done on cycle 32 after accept.
- divu 100/7 → result=14, result_hi=2, div_zero=0, latency 32. divu 9/0 → result=0xFFFFFFFF, result_hi=9, div_zero=1, latency 1.
- Handshake: start a new op on every cycle during multu → all ignored, result unchanged. A new start in the done cycle is accepted, and its result appears next.
- Reset at iteration 10 of divu → busy=0, no done pulse. A following add 2+3 → 5 with latency 1.
